// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit indices, hex glyph patterns and
// block defaults, used by both the segment encoder and the receive decoder.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam int STABLE_CYCLES_DEFAULT = 4;
    localparam int PERIOD_CNT_W_DEFAULT  = 24;

    localparam logic [6:0] M_A = 7'(1) << SEG_A;
    localparam logic [6:0] M_B = 7'(1) << SEG_B;
    localparam logic [6:0] M_C = 7'(1) << SEG_C;
    localparam logic [6:0] M_D = 7'(1) << SEG_D;
    localparam logic [6:0] M_E = 7'(1) << SEG_E;
    localparam logic [6:0] M_F = 7'(1) << SEG_F;
    localparam logic [6:0] M_G = 7'(1) << SEG_G;

    // Glyphs built from segment masks so the bit order lives in one place.
    localparam logic [6:0] SEG7_HEX_0 = M_A | M_B | M_C | M_D | M_E | M_F;
    localparam logic [6:0] SEG7_HEX_1 = M_B | M_C;
    localparam logic [6:0] SEG7_HEX_2 = M_A | M_B | M_D | M_E | M_G;
    localparam logic [6:0] SEG7_HEX_3 = M_A | M_B | M_C | M_D | M_G;
    localparam logic [6:0] SEG7_HEX_4 = M_B | M_C | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_5 = M_A | M_C | M_D | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_6 = M_A | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_7 = M_A | M_B | M_C;
    localparam logic [6:0] SEG7_HEX_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_9 = M_A | M_B | M_C | M_D | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_A = M_A | M_B | M_C | M_E | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_B = M_C | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_C = M_A | M_D | M_E | M_F;
    localparam logic [6:0] SEG7_HEX_D = M_B | M_C | M_D | M_E | M_G;
    localparam logic [6:0] SEG7_HEX_E = M_A | M_D | M_E | M_F | M_G;
    localparam logic [6:0] SEG7_HEX_F = M_A | M_E | M_F | M_G;

    typedef struct packed {
        logic       known;
        logic [3:0] value;
    } glyph_t;

endpackage

// File: rtl/seg7_glyph_lookup.sv
// Combinational reverse lookup of a segment pattern to its hex value;
// patterns outside the 16 glyphs report known=0, value=0.
module seg7_glyph_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output glyph_t     glyph
);

    always_comb begin
        glyph.known = 1'b1;
        glyph.value = 4'h0;
        case (pattern)
            SEG7_HEX_0: glyph.value = 4'h0;
            SEG7_HEX_1: glyph.value = 4'h1;
            SEG7_HEX_2: glyph.value = 4'h2;
            SEG7_HEX_3: glyph.value = 4'h3;
            SEG7_HEX_4: glyph.value = 4'h4;
            SEG7_HEX_5: glyph.value = 4'h5;
            SEG7_HEX_6: glyph.value = 4'h6;
            SEG7_HEX_7: glyph.value = 4'h7;
            SEG7_HEX_8: glyph.value = 4'h8;
            SEG7_HEX_9: glyph.value = 4'h9;
            SEG7_HEX_A: glyph.value = 4'hA;
            SEG7_HEX_B: glyph.value = 4'hB;
            SEG7_HEX_C: glyph.value = 4'hC;
            SEG7_HEX_D: glyph.value = 4'hD;
            SEG7_HEX_E: glyph.value = 4'hE;
            SEG7_HEX_F: glyph.value = 4'hF;
            default: begin
                glyph.known = 1'b0;
                glyph.value = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Receive side of the 7-segment link: synchronizes and glitch-filters the
// segment pattern, decodes accepted patterns and measures the frame period.
module seg7_rx_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = PERIOD_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_known,
    output logic             blank,
    output logic             frame_valid,
    output logic [CNT_W-1:0] frame_period,
    output logic             period_valid
);

    localparam int FW = $clog2(STABLE_CYCLES);
    localparam logic [FW-1:0] CNT_LAST = FW'(STABLE_CYCLES - 1);

    logic [6:0]       sync_meta;
    logic [6:0]       sync_q;
    logic [6:0]       candidate;
    logic [6:0]       accepted;
    logic [FW-1:0]    cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             seen_first;

    logic             accept;
    logic [CNT_W:0]   period_inc;
    logic [CNT_W-1:0] period_sat;
    glyph_t           cand_glyph;

    seg7_glyph_lookup u_lookup (
        .pattern (candidate),
        .glyph   (cand_glyph)
    );

    // Synchronizer keeps sampling regardless of ena so resumption sees fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 7'h00;
            sync_q    <= 7'h00;
        end else begin
            sync_meta <= seg_in;
            sync_q    <= sync_meta;
        end
    end

    assign accept = ena && (sync_q == candidate) && (cnt == CNT_LAST)
                    && (candidate != accepted);

    // One saturating +1 serves both the free-running counter and the latched period.
    assign period_inc = {1'b0, period_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign period_sat = period_inc[CNT_W] ? {CNT_W{1'b1}} : period_inc[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate    <= 7'h00;
            accepted     <= 7'h00;
            cnt          <= '0;
            period_cnt   <= '0;
            seen_first   <= 1'b0;
            digit        <= 4'h0;
            digit_known  <= 1'b0;
            blank        <= 1'b1;
            frame_valid  <= 1'b0;
            frame_period <= '0;
            period_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (ena) begin
                if (sync_q != candidate) begin
                    candidate <= sync_q;
                    cnt       <= '0;
                end else if (cnt < CNT_LAST) begin
                    cnt <= cnt + FW'(1);
                end

                if (accept) begin
                    accepted    <= candidate;
                    frame_valid <= 1'b1;
                    digit       <= cand_glyph.value;
                    digit_known <= cand_glyph.known;
                    blank       <= (candidate == 7'h00);
                    period_cnt  <= '0;
                    seen_first  <= 1'b1;
                    if (seen_first) begin
                        frame_period <= period_sat;
                        period_valid <= 1'b1;
                    end
                end else begin
                    period_cnt <= period_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Bench for seg7_rx_decoder: directed scenarios plus random patterns, every
// cycle compared against a history-based reference model.
module tb_seg7_rx_decoder;

    localparam int S     = 4;
    localparam int CW    = 24;
    localparam int MAXP  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [6:0]    seg_in;
    logic [3:0]    digit;
    logic          digit_known;
    logic          blank;
    logic          frame_valid;
    logic [CW-1:0] frame_period;
    logic          period_valid;

    int checks;
    int errors;

    logic [6:0] glyph [16];

    // Reference model state: raw input history, run of identical filter samples,
    // accepted value and enabled clocks since the last accept.
    logic [6:0]  seg_hist [$];
    logic [6:0]  run_val;
    int          run_len;
    logic [6:0]  acc_val;
    int          elapsed;
    bit          seen;
    logic [3:0]  exp_digit;
    logic        exp_known;
    logic        exp_blank;
    logic        exp_fv;
    logic [31:0] exp_period;
    logic        exp_pv;

    seg7_rx_decoder #(
        .STABLE_CYCLES (S),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .seg_in       (seg_in),
        .digit        (digit),
        .digit_known  (digit_known),
        .blank        (blank),
        .frame_valid  (frame_valid),
        .frame_period (frame_period),
        .period_valid (period_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        seg_hist   = '{7'h00, 7'h00};
        run_val    = 7'h00;
        run_len    = 0;
        acc_val    = 7'h00;
        elapsed    = 0;
        seen       = 1'b0;
        exp_digit  = 4'h0;
        exp_known  = 1'b0;
        exp_blank  = 1'b1;
        exp_fv     = 1'b0;
        exp_period = 32'h0;
        exp_pv     = 1'b0;
    endtask

    // A pattern is accepted once the filter has seen it on S+1 consecutive
    // enabled clocks (two clocks after it appears at the pins) and it differs
    // from the currently accepted pattern.
    task automatic model_edge();
        logic [6:0] obs;
        seg_hist.push_back(seg_in);
        obs = seg_hist[0];
        void'(seg_hist.pop_front());
        exp_fv = 1'b0;
        if (ena) begin
            elapsed++;
            if (obs == run_val) run_len++;
            else begin
                run_val = obs;
                run_len = 1;
            end
            if (run_len >= S + 1 && run_val != acc_val) begin
                acc_val = run_val;
                exp_fv  = 1'b1;
                if (seen) begin
                    exp_period = (elapsed > MAXP) ? 32'(MAXP) : 32'(elapsed);
                    exp_pv     = 1'b1;
                end
                seen      = 1'b1;
                elapsed   = 0;
                exp_known = 1'b0;
                exp_digit = 4'h0;
                for (int i = 0; i < 16; i++) begin
                    if (glyph[i] == run_val) begin
                        exp_known = 1'b1;
                        exp_digit = 4'(i);
                    end
                end
                exp_blank = (run_val == 7'h00);
            end
        end
    endtask

    task automatic check_outputs();
        chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
        chk("digit", 32'(digit), 32'(exp_digit));
        chk("digit_known", 32'(digit_known), 32'(exp_known));
        chk("blank", 32'(blank), 32'(exp_blank));
        chk("frame_period", 32'(frame_period), exp_period);
        chk("period_valid", 32'(period_valid), 32'(exp_pv));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_outputs();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases after two edges.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_known", 32'(digit_known), 32'h0);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_period", 32'(frame_period), 32'h0);
        chk("rst_pv", 32'(period_valid), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        int lat2;
        int pulses;
        int per;
        int pv_first;
        int pv_second;
        logic [6:0] pat;
        int hold;

        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        checks = 0;
        errors = 0;
        ena    = 1'b1;
        seg_in = 7'h00;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        apply_reset();

        // Idle with a blank input: nothing accepted.
        pulses = 0;
        repeat (20) begin
            tick();
            pulses += int'(frame_valid);
        end
        chk("idle_pulses", 32'(pulses), 32'h0);
        chk("idle_blank", 32'(blank), 32'h1);
        chk("idle_pv", 32'(period_valid), 32'h0);

        // 00 -> 06: pulse seven clocks after the change.
        seg_in = 7'h06;
        lat = -1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (frame_valid && lat < 0) lat = i;
        end
        chk("latency", 32'(lat), 32'd7);
        chk("digit_1", 32'(digit), 32'h1);
        chk("known_1", 32'(digit_known), 32'h1);

        // Three-clock glitch to 5B is filtered out.
        pulses = 0;
        seg_in = 7'h5B;
        repeat (3) begin
            tick();
            pulses += int'(frame_valid);
        end
        seg_in = 7'h06;
        repeat (15) begin
            tick();
            pulses += int'(frame_valid);
        end
        chk("glitch_pulses", 32'(pulses), 32'h0);
        chk("glitch_digit", 32'(digit), 32'h1);

        // Period: 3F then 4F with input changes 100 clocks apart.
        apply_reset();
        seg_in = 7'h3F;
        lat = -1;
        pv_first = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (frame_valid && lat < 0) begin
                lat = i;
                pv_first = int'(period_valid);
            end
        end
        seg_in = 7'h4F;
        lat2 = -1;
        per = -1;
        pv_second = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (frame_valid && lat2 < 0) begin
                lat2 = i;
                per = int'(frame_period);
                pv_second = int'(period_valid);
            end
        end
        chk("first_lat", 32'(lat), 32'd7);
        chk("first_pv", 32'(pv_first), 32'h0);
        chk("second_lat", 32'(lat2), 32'd7);
        chk("period_100", 32'(per), 32'd100);
        chk("second_pv", 32'(pv_second), 32'h1);

        // Non-glyph pattern.
        seg_in = 7'h2A;
        pulses = 0;
        repeat (15) begin
            tick();
            pulses += int'(frame_valid);
        end
        chk("2a_pulses", 32'(pulses), 32'h1);
        chk("2a_known", 32'(digit_known), 32'h0);
        chk("2a_digit", 32'(digit), 32'h0);
        chk("2a_blank", 32'(blank), 32'h0);

        // Change 06 -> 66 while disabled: accepted only after re-enable.
        seg_in = 7'h06;
        repeat (12) tick();
        ena = 1'b0;
        seg_in = 7'h66;
        pulses = 0;
        repeat (20) begin
            tick();
            pulses += int'(frame_valid);
        end
        chk("ena_off_pulses", 32'(pulses), 32'h0);
        chk("ena_off_digit", 32'(digit), 32'h1);
        ena = 1'b1;
        lat = -1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (frame_valid && lat < 0) lat = i;
        end
        chk("ena_on_lat", 32'(lat), 32'd5);
        chk("ena_on_digit", 32'(digit), 32'h4);

        // Random patterns, hold times and enable gaps.
        repeat (200) begin
            if ($urandom_range(0, 3) == 0) pat = 7'($urandom_range(0, 127));
            else pat = glyph[$urandom_range(0, 15)];
            seg_in = pat;
            ena = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(1, 12);
            repeat (hold) tick();
            if ($urandom_range(0, 49) == 0) apply_reset();
        end
        ena = 1'b1;

        // Reset in the middle of a filter count; next accept latches no period.
        seg_in = 7'h7F;
        repeat (3) tick();
        apply_reset();
        seg_in = 7'h6D;
        pulses = 0;
        repeat (15) begin
            tick();
            pulses += int'(frame_valid);
        end
        chk("post_rst_pulses", 32'(pulses), 32'h1);
        chk("post_rst_digit", 32'(digit), 32'h5);
        chk("post_rst_pv", 32'(period_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
